// File: rtl/ethpipe_pkg.sv
// Shared types and constants for the ethpipe RX slot engine.
// Build option: ETHPIPE_RX_FCS_STRIP_EN makes reported frame lengths exclude the FCS.
package ethpipe_pkg;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        HUNT      = 2'd1,
        DATA      = 2'd2,
        DROP      = 2'd3
    } rx_state_e;

    localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
    localparam logic [7:0]  ETH_SFD       = 8'hD5;
    localparam int unsigned ETH_MIN_BYTES = 14;
    localparam int unsigned ETH_FCS_BYTES = 4;

`ifdef ETHPIPE_RX_FCS_STRIP_EN
    localparam logic FCS_STRIP = 1'b1;
`else
    localparam logic FCS_STRIP = 1'b0;
`endif

    // Reported length from the raw byte count; the slot RAM always holds the FCS.
    function automatic logic [15:0] frame_len(input logic [15:0] raw);
        return raw - (FCS_STRIP ? 16'(ETH_FCS_BYTES) : 16'd0);
    endfunction

endpackage

// File: rtl/ethpipe_rx_slots_if.sv
// Slot RAM write port driven by the RX engine.
interface ethpipe_rx_slots_if #(
    parameter int DATA_WIDTH = 32,
    parameter int AW         = 11
) ();
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] byte_en;
    logic [AW-1:0]           address;
    logic                    wr_en;

    modport master (output data, output byte_en, output address, output wr_en);
    modport slave  (input  data, input  byte_en, input  address, input  wr_en);
endinterface

// File: rtl/ethpipe_rx_slot_alloc.sv
// Slot ownership: busy bitmap, round-robin fill pointer, release/complete arbitration.
module ethpipe_rx_slot_alloc #(
    parameter  int NSLOT = 4,
    localparam int SW    = $clog2(NSLOT)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             complete_i,
    input  logic             release_i,
    input  logic [SW-1:0]    release_slot_i,
    output logic [NSLOT-1:0] busy_o,
    output logic [SW-1:0]    ptr_o,
    output logic             free_at_ptr_o
);

    logic [NSLOT-1:0] busy_q, busy_d;
    logic [SW-1:0]    ptr_q, ptr_d;

    // Next bitmap/pointer; a completing slot always ends up busy even if released this cycle.
    always_comb begin
        busy_d = busy_q;
        ptr_d  = ptr_q;
        if (release_i && busy_q[release_slot_i] && !(complete_i && (release_slot_i == ptr_q))) begin
            busy_d[release_slot_i] = 1'b0;
        end else begin
            busy_d = busy_q;
        end
        if (complete_i) begin
            busy_d[ptr_q] = 1'b1;
            ptr_d         = ptr_q + SW'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Ownership state registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            busy_q <= '0;
            ptr_q  <= '0;
        end else begin
            busy_q <= busy_d;
            ptr_q  <= ptr_d;
        end
    end

    assign busy_o        = busy_q;
    assign ptr_o         = ptr_q;
    assign free_at_ptr_o = ~busy_q[ptr_q];

endmodule

// File: rtl/ethpipe_rx_slots.sv
// GMII receive engine: strips preamble/SFD and stores frames into round-robin slots.
// Build option: ETHPIPE_RX_FCS_STRIP_EN (see ethpipe_pkg::frame_len).
module ethpipe_rx_slots
    import ethpipe_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int NSLOT      = 4,
    parameter  int SLOT_AW    = 9,
    localparam int SW         = $clog2(NSLOT)
) (
    input  logic                 gmii_rx_clk,
    input  logic                 sys_rst_n,
    input  logic [7:0]           gmii_rxd,
    input  logic                 gmii_rx_dv,
    input  logic [63:0]          global_counter,
    ethpipe_rx_slots_if.master   slot_rx_eth,
    output logic                 rx_complete,
    output logic [SW-1:0]        rx_slot,
    output logic [15:0]          rx_frame_len,
    output logic [63:0]          rx_timestamp,
    input  logic                 rx_release,
    input  logic [SW-1:0]        rx_release_slot,
    output logic [NSLOT-1:0]     rx_slot_busy,
    output logic [31:0]          rx_drop_count
);

    localparam int BPW = DATA_WIDTH / 8;
    localparam int LW  = $clog2(BPW);
    localparam int CW  = SLOT_AW + LW + 1;
    localparam logic [CW-1:0] CAP = CW'(1) << (SLOT_AW + LW);

    rx_state_e               state_q, state_d;
    logic [CW-1:0]           count_q, count_d;
    logic [63:0]             sfd_ts_q, sfd_ts_d;
    logic                    wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [BPW-1:0]          be_q, be_d;
    logic [SW+SLOT_AW-1:0]   addr_q, addr_d;
    logic                    complete_q, complete_d;
    logic [SW-1:0]           slot_q, slot_d;
    logic [15:0]             len_q, len_d;
    logic [63:0]             ts_q, ts_d;
    logic [31:0]             drop_q, drop_d;
    logic                    drop_inc_s;
    logic [SW-1:0]           ptr_s;
    logic                    free_at_ptr_s;
    logic [LW-1:0]           lane_s;
    logic [SLOT_AW-1:0]      word_s;

    assign lane_s = count_q[LW-1:0];
    assign word_s = count_q[LW +: SLOT_AW];

    ethpipe_rx_slot_alloc #(.NSLOT(NSLOT)) u_alloc (
        .clk_i          (gmii_rx_clk),
        .rst_n_i        (sys_rst_n),
        .complete_i     (complete_d),
        .release_i      (rx_release),
        .release_slot_i (rx_release_slot),
        .busy_o         (rx_slot_busy),
        .ptr_o          (ptr_s),
        .free_at_ptr_o  (free_at_ptr_s)
    );

    // Receive FSM next state and next values of every registered output.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        sfd_ts_d   = sfd_ts_q;
        wr_en_d    = 1'b0;
        data_d     = data_q;
        be_d       = be_q;
        addr_d     = addr_q;
        complete_d = 1'b0;
        slot_d     = slot_q;
        len_d      = len_q;
        ts_d       = ts_q;
        drop_inc_s = 1'b0;
        case (state_q)
            WAIT_IDLE: begin
                if (!gmii_rx_dv) state_d = HUNT;
                else             state_d = WAIT_IDLE;
            end
            HUNT: begin
                if (!gmii_rx_dv) begin
                    state_d = HUNT;
                end else if (gmii_rxd == ETH_PREAMBLE) begin
                    state_d = HUNT;
                end else if (gmii_rxd == ETH_SFD) begin
                    sfd_ts_d = global_counter;
                    count_d  = '0;
                    // No search for another slot: a busy slot at the pointer drops the frame.
                    if (free_at_ptr_s) begin
                        state_d = DATA;
                    end else begin
                        state_d    = DROP;
                        drop_inc_s = 1'b1;
                    end
                end else begin
                    state_d = DROP;
                end
            end
            DATA: begin
                if (gmii_rx_dv) begin
                    if (count_q == CAP) begin
                        state_d    = DROP;
                        drop_inc_s = 1'b1;
                    end else begin
                        wr_en_d = 1'b1;
                        data_d  = DATA_WIDTH'(gmii_rxd) << {lane_s, 3'b000};
                        be_d    = BPW'(1) << lane_s;
                        addr_d  = {ptr_s, word_s};
                        count_d = count_q + CW'(1);
                    end
                end else begin
                    state_d = HUNT;
                    // Runts leave the pointer alone so the same slot is overwritten next.
                    if (count_q < CW'(ETH_MIN_BYTES)) begin
                        drop_inc_s = 1'b1;
                    end else begin
                        complete_d = 1'b1;
                        slot_d     = ptr_s;
                        len_d      = frame_len(16'(count_q));
                        ts_d       = sfd_ts_q;
                    end
                end
            end
            DROP: begin
                if (!gmii_rx_dv) state_d = HUNT;
                else             state_d = DROP;
            end
            default: begin
                state_d = WAIT_IDLE;
            end
        endcase
        if (drop_inc_s && (drop_q != 32'hFFFF_FFFF)) drop_d = drop_q + 32'd1;
        else                                         drop_d = drop_q;
    end

    // State and output registers.
    always_ff @(posedge gmii_rx_clk) begin
        if (!sys_rst_n) begin
            state_q    <= WAIT_IDLE;
            count_q    <= '0;
            sfd_ts_q   <= 64'd0;
            wr_en_q    <= 1'b0;
            data_q     <= '0;
            be_q       <= '0;
            addr_q     <= '0;
            complete_q <= 1'b0;
            slot_q     <= '0;
            len_q      <= 16'd0;
            ts_q       <= 64'd0;
            drop_q     <= 32'd0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            sfd_ts_q   <= sfd_ts_d;
            wr_en_q    <= wr_en_d;
            data_q     <= data_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            complete_q <= complete_d;
            slot_q     <= slot_d;
            len_q      <= len_d;
            ts_q       <= ts_d;
            drop_q     <= drop_d;
        end
    end

    assign slot_rx_eth.wr_en   = wr_en_q;
    assign slot_rx_eth.data    = data_q;
    assign slot_rx_eth.byte_en = be_q;
    assign slot_rx_eth.address = addr_q;
    assign rx_complete         = complete_q;
    assign rx_slot             = slot_q;
    assign rx_frame_len        = len_q;
    assign rx_timestamp        = ts_q;
    assign rx_drop_count       = drop_q;

endmodule

// File: tb/tb_ethpipe_rx_slots.sv
// Directed bench for ethpipe_rx_slots (DATA_WIDTH=32, NSLOT=4, SLOT_AW=9).
module tb_ethpipe_rx_slots;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rxd;
    logic        dv;
    logic [63:0] gc = 64'h0123_4567_89AB_0000;
    logic        rel;
    logic [1:0]  rel_slot;
    logic        rx_complete;
    logic [1:0]  rx_slot;
    logic [15:0] rx_frame_len;
    logic [63:0] rx_timestamp;
    logic [3:0]  rx_slot_busy;
    logic [31:0] rx_drop_count;

    ethpipe_rx_slots_if #(.DATA_WIDTH(32), .AW(11)) sif ();

    ethpipe_rx_slots #(.DATA_WIDTH(32), .NSLOT(4), .SLOT_AW(9)) dut (
        .gmii_rx_clk     (clk),
        .sys_rst_n       (rst_n),
        .gmii_rxd        (rxd),
        .gmii_rx_dv      (dv),
        .global_counter  (gc),
        .slot_rx_eth     (sif),
        .rx_complete     (rx_complete),
        .rx_slot         (rx_slot),
        .rx_frame_len    (rx_frame_len),
        .rx_timestamp    (rx_timestamp),
        .rx_release      (rel),
        .rx_release_slot (rel_slot),
        .rx_slot_busy    (rx_slot_busy),
        .rx_drop_count   (rx_drop_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) gc <= gc + 64'd1;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          wr_cnt   = 0;
    int          cmp_cnt  = 0;
    int          exp_drop = 0;
    logic [63:0] sfd_ts;
    logic [31:0] log_addr [4096];
    logic [3:0]  log_be   [4096];
    logic [31:0] log_data [4096];

    typedef struct {
        int         len;
        int         wr;
        int         cmp;
        int         slot;
        int         drop;
        logic [3:0] busy;
    } vec_t;
    vec_t vecs [7];

    // Write and completion monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (sif.wr_en) begin
            if (wr_cnt < 4096) begin
                log_addr[wr_cnt] = 32'(sif.address);
                log_be[wr_cnt]   = sif.byte_en;
                log_data[wr_cnt] = sif.data;
            end
            wr_cnt++;
        end
        if (rx_complete) cmp_cnt++;
    end

    function automatic logic [63:0] exp_len(input int n);
`ifdef ETHPIPE_RX_FCS_STRIP_EN
        return 64'(n - 4);
`else
        return 64'(n);
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic v, input logic [7:0] d);
        @(posedge clk);
        #1;
        dv  = v;
        rxd = d;
    endtask

    task automatic preamble_sfd();
        for (int i = 0; i < 7; i++) send_byte(1'b1, 8'h55);
        send_byte(1'b1, 8'hD5);
        sfd_ts = gc;
    endtask

    task automatic send_frame(input int n);
        wr_cnt  = 0;
        cmp_cnt = 0;
        preamble_sfd();
        for (int i = 0; i < n; i++) send_byte(1'b1, 8'(i));
        for (int i = 0; i < 4; i++) send_byte(1'b0, 8'h00);
        @(negedge clk);
    endtask

    task automatic pulse_release(input logic [1:0] s);
        @(posedge clk);
        #1;
        rel      = 1'b1;
        rel_slot = s;
        @(posedge clk);
        #1;
        rel = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset_vals();
        check("rst_wr_en", 64'(sif.wr_en), 64'd0);
        check("rst_byte_en", 64'(sif.byte_en), 64'd0);
        check("rst_data", 64'(sif.data), 64'd0);
        check("rst_address", 64'(sif.address), 64'd0);
        check("rst_complete", 64'(rx_complete), 64'd0);
        check("rst_slot", 64'(rx_slot), 64'd0);
        check("rst_len", 64'(rx_frame_len), 64'd0);
        check("rst_ts", rx_timestamp, 64'd0);
        check("rst_busy", 64'(rx_slot_busy), 64'd0);
        check("rst_drop", 64'(rx_drop_count), 64'd0);
    endtask

    initial begin
        vecs[0] = '{64, 64, 1, 0, 0, 4'b0001};
        vecs[1] = '{20, 20, 1, 1, 0, 4'b0011};
        vecs[2] = '{10, 10, 0, 2, 1, 4'b0011};
        vecs[3] = '{14, 14, 1, 2, 0, 4'b0111};
        vecs[4] = '{13, 13, 0, 3, 1, 4'b0111};
        vecs[5] = '{30, 30, 1, 3, 0, 4'b1111};
        vecs[6] = '{30,  0, 0, 0, 1, 4'b1111};

        rst_n = 1'b0; dv = 1'b0; rxd = 8'h00; rel = 1'b0; rel_slot = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].len);
            exp_drop += vecs[i].drop;
            check("writes", 64'(wr_cnt), 64'(vecs[i].wr));
            check("complete_pulses", 64'(cmp_cnt), 64'(vecs[i].cmp));
            check("drop_count", 64'(rx_drop_count), 64'(exp_drop));
            check("busy", 64'(rx_slot_busy), 64'(vecs[i].busy));
            if (vecs[i].wr > 0) check("first_addr", 64'(log_addr[0]), 64'(vecs[i].slot * 512));
            if (vecs[i].cmp > 0) begin
                check("rx_slot", 64'(rx_slot), 64'(vecs[i].slot));
                check("frame_len", 64'(rx_frame_len), exp_len(vecs[i].len));
                check("timestamp", rx_timestamp, sfd_ts);
            end
            if (i == 0) begin
                check("b5_addr", 64'(log_addr[5]), 64'd1);
                check("b5_be", 64'(log_be[5]), 64'h2);
                check("b5_data", 64'(log_data[5]), 64'h0000_0500);
                check("b63_addr", 64'(log_addr[63]), 64'd15);
                check("b63_data", 64'(log_data[63]), 64'h3F00_0000);
            end
        end

        // Release slot 0, which is the slot the pointer sits on.
        pulse_release(2'd0);
        check("busy_after_rel0", 64'(rx_slot_busy), 64'hE);
        send_frame(16);
        check("reuse_complete", 64'(cmp_cnt), 64'd1);
        check("reuse_slot", 64'(rx_slot), 64'd0);
        check("reuse_busy", 64'(rx_slot_busy), 64'hF);

        // Oversize frame into slot 1.
        pulse_release(2'd1);
        send_frame(2049);
        exp_drop++;
        check("ovs_writes", 64'(wr_cnt), 64'd2048);
        check("ovs_complete", 64'(cmp_cnt), 64'd0);
        check("ovs_drop", 64'(rx_drop_count), 64'(exp_drop));
        check("ovs_busy", 64'(rx_slot_busy), 64'hD);
        check("ovs_first_addr", 64'(log_addr[0]), 64'h200);
        check("ovs_last_addr", 64'(log_addr[2047]), 64'h3FF);
        check("ovs_last_be", 64'(log_be[2047]), 64'h8);
        check("ovs_last_data", 64'(log_data[2047]), 64'hFF00_0000);

        // Preamble-only burst, then a bad delimiter byte.
        wr_cnt = 0;
        for (int i = 0; i < 4; i++) send_byte(1'b1, 8'h55);
        for (int i = 0; i < 3; i++) send_byte(1'b0, 8'h00);
        for (int i = 0; i < 3; i++) send_byte(1'b1, 8'h55);
        for (int i = 0; i < 8; i++) send_byte(1'b1, 8'hA0 + 8'(i));
        for (int i = 0; i < 3; i++) send_byte(1'b0, 8'h00);
        @(negedge clk);
        check("pre_writes", 64'(wr_cnt), 64'd0);
        check("pre_drop", 64'(rx_drop_count), 64'(exp_drop));

        // Completion into slot 1 with a release of slot 2 in the same cycle.
        preamble_sfd();
        send_byte(1'b1, 8'h00);
        @(negedge clk);
        check("wr_latency_early", 64'(sif.wr_en), 64'd0);
        send_byte(1'b1, 8'h01);
        @(negedge clk);
        check("wr_latency_one", 64'(sif.wr_en), 64'd1);
        check("sim_first_addr", 64'(sif.address), 64'h200);
        for (int i = 2; i < 20; i++) send_byte(1'b1, 8'(i));
        @(posedge clk);
        #1;
        dv = 1'b0; rel = 1'b1; rel_slot = 2'd2;
        @(negedge clk);
        check("cmp_not_early", 64'(rx_complete), 64'd0);
        @(posedge clk);
        #1;
        rel = 1'b0;
        @(negedge clk);
        check("cmp_pulse", 64'(rx_complete), 64'd1);
        check("sim_busy", 64'(rx_slot_busy), 64'hB);
        check("sim_slot", 64'(rx_slot), 64'd1);
        check("sim_len", 64'(rx_frame_len), exp_len(20));

        // Release aimed at the slot completing in the same cycle is ignored.
        repeat (2) send_byte(1'b0, 8'h00);
        preamble_sfd();
        for (int i = 0; i < 20; i++) send_byte(1'b1, 8'(i));
        @(posedge clk);
        #1;
        dv = 1'b0; rel = 1'b1; rel_slot = 2'd2;
        @(posedge clk);
        #1;
        rel = 1'b0;
        @(negedge clk);
        check("same_slot_busy", 64'(rx_slot_busy), 64'hF);
        check("same_slot_slot", 64'(rx_slot), 64'd2);

        // Reset in the middle of a frame into slot 3.
        pulse_release(2'd3);
        check("busy_after_rel3", 64'(rx_slot_busy), 64'h7);
        preamble_sfd();
        for (int i = 0; i < 20; i++) send_byte(1'b1, 8'(i));
        @(posedge clk);
        #1;
        rst_n = 1'b0; rxd = 8'd20;
        send_byte(1'b1, 8'd21);
        @(negedge clk);
        check_reset_vals();
        wr_cnt = 0;
        cmp_cnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1; rxd = 8'h55;
        send_byte(1'b1, 8'hD5);
        for (int i = 0; i < 8; i++) send_byte(1'b1, 8'h10 + 8'(i));
        for (int i = 0; i < 3; i++) send_byte(1'b0, 8'h00);
        @(negedge clk);
        check("rst_tail_writes", 64'(wr_cnt), 64'd0);
        check("rst_tail_complete", 64'(cmp_cnt), 64'd0);
        send_frame(16);
        check("post_rst_complete", 64'(cmp_cnt), 64'd1);
        check("post_rst_slot", 64'(rx_slot), 64'd0);
        check("post_rst_busy", 64'(rx_slot_busy), 64'h1);
        check("post_rst_addr", 64'(log_addr[0]), 64'd0);
        check("post_rst_drop", 64'(rx_drop_count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
